// File: rtl/voq_scheduler.sv
// voq_scheduler: iSLIP-style grant/accept matcher for an EGRESS_CNT x EGRESS_CNT
// crossbar fed by virtual output queues. Each start computes one schedule in
// ITER_CNT grant/accept rounds. Outputs always form a full permutation, so the
// crossbar never sees two ingresses driving the same egress.
// Optional feature: define SCHED_STATS_EN to keep a saturating match counter on
// match_cnt; without it match_cnt is tied to zero.

// Round-robin picker: first set bit of req at or after ptr, wrapping.
module voq_rr_pick #(
  parameter int N     = 4,
  parameter int SEL_W = 2
) (
  input  logic [N-1:0]     req,
  input  logic [SEL_W-1:0] ptr,
  output logic             vld,
  output logic [SEL_W-1:0] sel
);
  logic [SEL_W-1:0] idx;

  // Scan from the farthest offset down so the nearest hit to ptr wins.
  always_comb begin
    vld = 1'b0;
    sel = '0;
    idx = '0;
    for (int k = N - 1; k >= 0; k--) begin
      idx = ptr + SEL_W'(k);
      if (req[idx]) begin
        vld = 1'b1;
        sel = idx;
      end
    end
  end
endmodule

module voq_scheduler #(
  parameter int EGRESS_CNT = 4,
  parameter int ITER_CNT   = 2,
  localparam int SEL_W     = $clog2(EGRESS_CNT)
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        start,
  input  logic [EGRESS_CNT*EGRESS_CNT-1:0] voq_req,
  output logic                        busy,
  output logic                        done,
  output logic [SEL_W*EGRESS_CNT-1:0] sched_sel,
  output logic [EGRESS_CNT-1:0]       sched_en,
  output logic [15:0]                 match_cnt
);
  localparam int N    = EGRESS_CNT;
  localparam int IT_W = $clog2(ITER_CNT + 1);

  typedef enum logic [1:0] {IDLE, GRANT, ACCEPT, DONE} state_t;

  state_t                    state;
  logic [N-1:0][N-1:0]       req_q;       // req_q[i][e]: snapshot of voq_req
  logic [N-1:0]              in_m;        // ingress matched
  logic [N-1:0]              out_m;       // egress matched
  logic [N-1:0][SEL_W-1:0]   match_egr;   // egress matched to each ingress
  logic [N-1:0][SEL_W-1:0]   grant_ptr;
  logic [N-1:0][SEL_W-1:0]   accept_ptr;
  logic [N-1:0]              gnt_vld_q;   // egress e issued a grant this round
  logic [N-1:0][SEL_W-1:0]   gnt_ing_q;   // ingress granted by egress e
  logic [IT_W-1:0]           iter;

  logic [N-1:0][N-1:0]       g_req;       // g_req[e][i]
  logic [N-1:0][N-1:0]       a_req;       // a_req[i][e]
  logic [N-1:0]              g_vld, a_vld;
  logic [N-1:0][SEL_W-1:0]   g_sel, a_sel;

  logic [N-1:0][SEL_W-1:0]   perm;
  logic [N-1:0]              used;
  logic                      found;

  logic [N-1:0][SEL_W-1:0]   sel_q;
  logic [N-1:0]              en_q;

  assign sched_sel = sel_q;
  assign sched_en  = en_q;

  // Candidate vectors for the grant and accept pickers; matched ports drop out.
  always_comb begin
    g_req = '0;
    a_req = '0;
    for (int e = 0; e < N; e++)
      for (int i = 0; i < N; i++)
        g_req[e][i] = req_q[i][e] & ~in_m[i] & ~out_m[e];
    for (int i = 0; i < N; i++)
      for (int e = 0; e < N; e++)
        a_req[i][e] = gnt_vld_q[e] & (gnt_ing_q[e] == SEL_W'(i)) & ~in_m[i];
  end

  // One grant picker per egress and one accept picker per ingress.
  for (genvar g = 0; g < N; g++) begin : g_lane
    voq_rr_pick #(.N(N), .SEL_W(SEL_W)) u_gnt (
      .req (g_req[g]),
      .ptr (grant_ptr[g]),
      .vld (g_vld[g]),
      .sel (g_sel[g])
    );
    voq_rr_pick #(.N(N), .SEL_W(SEL_W)) u_acc (
      .req (a_req[g]),
      .ptr (accept_ptr[g]),
      .vld (a_vld[g]),
      .sel (a_sel[g])
    );
  end

  // Fill unmatched ingresses (ascending) with unused egresses (ascending).
  always_comb begin
    perm  = '0;
    used  = out_m;
    found = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (in_m[i]) begin
        perm[i] = match_egr[i];
      end else begin
        found = 1'b0;
        for (int e = 0; e < N; e++) begin
          if (!found && !used[e]) begin
            perm[i] = SEL_W'(e);
            used[e] = 1'b1;
            found   = 1'b1;
          end
        end
      end
    end
  end

  // Scheduler FSM: snapshot, ITER_CNT grant/accept rounds, then publish.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      en_q       <= '0;
      for (int i = 0; i < N; i++) sel_q[i] <= SEL_W'(i);
      grant_ptr  <= '0;
      accept_ptr <= '0;
      req_q      <= '0;
      in_m       <= '0;
      out_m      <= '0;
      match_egr  <= '0;
      gnt_vld_q  <= '0;
      gnt_ing_q  <= '0;
      iter       <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            req_q <= voq_req;
            in_m  <= '0;
            out_m <= '0;
            iter  <= '0;
            busy  <= 1'b1;
            state <= GRANT;
          end
        end
        GRANT: begin
          gnt_vld_q <= g_vld;
          gnt_ing_q <= g_sel;
          state     <= ACCEPT;
        end
        ACCEPT: begin
          for (int i = 0; i < N; i++) begin
            if (a_vld[i]) begin
              in_m[i]          <= 1'b1;
              out_m[a_sel[i]]  <= 1'b1;
              match_egr[i]     <= a_sel[i];
              // Only first-round accepts move pointers; this is what
              // desynchronises the grant pointers under load.
              if (iter == '0) begin
                accept_ptr[i]        <= a_sel[i] + SEL_W'(1);
                grant_ptr[a_sel[i]]  <= SEL_W'(i + 1);
              end
            end
          end
          if (iter == IT_W'(ITER_CNT - 1)) begin
            state <= DONE;
          end else begin
            iter  <= iter + IT_W'(1);
            state <= GRANT;
          end
        end
        DONE: begin
          sel_q <= perm;
          en_q  <= in_m;
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef SCHED_STATS_EN
  logic [SEL_W:0] pop;
  logic [15:0]    cnt_q;
  logic [16:0]    cnt_sum;

  // Number of matches in the schedule being published.
  always_comb begin
    pop = '0;
    for (int i = 0; i < N; i++) pop = pop + (SEL_W + 1)'(in_m[i]);
    cnt_sum = {1'b0, cnt_q} + 17'(pop);
  end

  // Saturating running total of matches, bumped alongside done.
  always_ff @(posedge clk) begin
    if (reset)
      cnt_q <= '0;
    else if (state == DONE)
      cnt_q <= cnt_sum[16] ? 16'hFFFF : cnt_sum[15:0];
  end

  assign match_cnt = cnt_q;
`else
  assign match_cnt = '0;
`endif

endmodule

// File: tb/tb_voq_scheduler.sv
// Testbench for voq_scheduler (EGRESS_CNT=4, ITER_CNT=2): directed corner
// cases plus randomized request matrices checked against an algorithmic
// iSLIP model. Honors SCHED_STATS_EN for the match counter expectation.
module tb_voq_scheduler;
  localparam int N  = 4;
  localparam int IT = 2;
`ifdef SCHED_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset, start;
  logic [15:0] voq_req;
  logic        busy, done;
  logic [7:0]  sched_sel;
  logic [3:0]  sched_en;
  logic [15:0] match_cnt;

  int n_cmp, n_err;
  int gp[N], ap[N];
  int exp_cnt;

  always #5 clk = ~clk;

  voq_scheduler #(.EGRESS_CNT(N), .ITER_CNT(IT)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .voq_req   (voq_req),
    .busy      (busy),
    .done      (done),
    .sched_sel (sched_sel),
    .sched_en  (sched_en),
    .match_cnt (match_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: iSLIP rounds on plain integer arrays, then permutation fill.
  task automatic model_run(input logic [15:0] req, output logic [3:0] en, output logic [7:0] sel);
    bit im[N], om[N], taken[N];
    int me[N], g[N];
    int pc;
    for (int k = 0; k < N; k++) begin im[k] = 0; om[k] = 0; taken[k] = 0; me[k] = 0; end
    for (int it = 0; it < IT; it++) begin
      for (int e = 0; e < N; e++) begin
        g[e] = -1;
        if (!om[e])
          for (int k = 0; k < N; k++) begin
            int i = (gp[e] + k) % N;
            if (g[e] < 0 && req[i*N+e] && !im[i]) g[e] = i;
          end
      end
      for (int i = 0; i < N; i++) begin
        int pick = -1;
        if (!im[i])
          for (int k = 0; k < N; k++) begin
            int e = (ap[i] + k) % N;
            if (pick < 0 && g[e] == i) pick = e;
          end
        if (pick >= 0) begin
          im[i] = 1; om[pick] = 1; me[i] = pick;
          if (it == 0) begin
            gp[pick] = (i + 1) % N;
            ap[i]    = (pick + 1) % N;
          end
        end
      end
    end
    for (int e = 0; e < N; e++) taken[e] = om[e];
    en = '0; sel = '0; pc = 0;
    for (int i = 0; i < N; i++) begin
      int d = 0;
      if (im[i]) begin
        d = me[i]; en[i] = 1'b1; pc++;
      end else begin
        d = -1;
        for (int e = 0; e < N; e++)
          if (d < 0 && !taken[e]) begin d = e; taken[e] = 1; end
      end
      sel[i*2 +: 2] = 2'(d);
    end
    if (STATS) exp_cnt = (exp_cnt + pc > 65535) ? 65535 : exp_cnt + pc;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < N; k++) begin gp[k] = 0; ap[k] = 0; end
    exp_cnt = 0;
  endtask

  // One schedule; optionally pulses start mid-run to check it is dropped.
  task automatic run(input logic [15:0] req, input bit ign, input string tag);
    logic [3:0] een, pen;
    logic [7:0] esel, psel;
    int lat;
    psel = sched_sel; pen = sched_en;
    model_run(req, een, esel);
    @(negedge clk);
    start = 1'b1; voq_req = req;
    @(negedge clk);
    start = 1'b0; voq_req = 16'($urandom);
    lat = 0;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      voq_req = 16'($urandom);
      start = ign && (c == 2);
      if (done) begin lat = c; break; end
      chk({tag, ".busy"}, busy, 1);
      chk({tag, ".hold_sel"}, sched_sel, psel);
      chk({tag, ".hold_en"}, sched_en, pen);
    end
    start = 1'b0;
    chk({tag, ".lat"}, lat, 2 * IT + 1);
    chk({tag, ".en"}, sched_en, een);
    chk({tag, ".sel"}, sched_sel, esel);
    chk({tag, ".busy_done"}, busy, 0);
    chk({tag, ".cnt"}, match_cnt, exp_cnt);
    for (int c = 0; c < (ign ? 6 : 1); c++) begin
      @(negedge clk);
      chk({tag, ".no_done"}, done, 0);
    end
    chk({tag, ".keep_sel"}, sched_sel, esel);
  endtask

  initial begin
    logic [31:0] r;
    n_cmp = 0; n_err = 0; exp_cnt = 0;
    reset = 1'b1; start = 1'b0; voq_req = '0;
    do_reset();
    chk("rst.busy", busy, 0);
    chk("rst.done", done, 0);
    chk("rst.en", sched_en, 4'b0000);
    chk("rst.sel", sched_sel, 8'hE4);
    chk("rst.cnt", match_cnt, 0);

    run(16'h0000, 1'b0, "empty");
    chk("empty.en_c", sched_en, 4'b0000);
    chk("empty.sel_c", sched_sel, 8'hE4);

    do_reset();
    run(16'h1842, 1'b0, "rot");
    chk("rot.en_c", sched_en, 4'b1111);
    chk("rot.sel_c", sched_sel, 8'h39);
    run(16'h4444, 1'b0, "rot_then_e2");
    chk("stats5", match_cnt, STATS ? 5 : 0);

    do_reset();
    run(16'h4444, 1'b0, "e2a");
    chk("e2a.en_c", sched_en, 4'b0001);
    chk("e2a.sel_c", sched_sel, 8'hD2);
    run(16'h4444, 1'b0, "e2b");
    chk("e2b.en_c", sched_en, 4'b0010);
    chk("e2b.sel_c", sched_sel, 8'hD8);

    do_reset();
    run(16'hFFFF, 1'b0, "full");
    chk("full.en_c", sched_en, 4'b0011);
    chk("full.sel_c", sched_sel, 8'hE4);
    // Pointers after full load: only grant_ptr[0] and accept_ptr[0] moved.
    run(16'h0001, 1'b0, "full_g0");   // egress0 from ptr 1: no one but ingress0
    run(16'h0011, 1'b0, "full_g0b");  // egress0 must now prefer ingress1

    // Abort mid-schedule.
    @(negedge clk);
    start = 1'b1; voq_req = 16'hFFFF;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0; reset = 1'b1;
    @(negedge clk);
    chk("abort.busy", busy, 0);
    chk("abort.done", done, 0);
    chk("abort.en", sched_en, 4'b0000);
    chk("abort.sel", sched_sel, 8'hE4);
    reset = 1'b0;
    for (int k = 0; k < N; k++) begin gp[k] = 0; ap[k] = 0; end
    exp_cnt = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      chk("abort.no_done", done, 0);
    end
    run(16'h0000, 1'b0, "post_abort");
    chk("post_abort.sel_c", sched_sel, 8'hE4);
    run(16'hFFFF, 1'b0, "post_full");
    chk("post_full.en_c", sched_en, 4'b0011);
    chk("post_full.sel_c", sched_sel, 8'hE4);

    // Randomized matrices with mixed density.
    for (int t = 0; t < 40; t++) begin
      r = $urandom;
      case ($urandom_range(0, 3))
        0: r = r & $urandom;
        1: r = r & $urandom & $urandom;
        2: if ($urandom_range(0, 3) == 0) r = 0;
        default: ;
      endcase
      run(r[15:0], 1'($urandom_range(0, 1)), "rnd");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/voq_scheduler.md
VOQ_SCHEDULER -- requirements
Module: voq_scheduler

Interface
REQ-001 Parameter EGRESS_CNT, default 4: port count (ingress = egress); power of two, at least 2; SEL_W = $clog2(EGRESS_CNT).
REQ-002 Parameter ITER_CNT, default 2: grant/accept iterations per schedule, at least 1.
REQ-003 clk  in  1  sole clock; all logic rising-edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 start  in  1  one-cycle request to compute a schedule; sampled only in IDLE.
REQ-006 voq_req  in  EGRESS_CNT*EGRESS_CNT  bit [i*EGRESS_CNT+e] set means ingress i holds a cell for egress e.
REQ-007 busy  out  1  high in every state except IDLE.
REQ-008 done  out  1  one-cycle pulse; the new schedule is valid on this cycle.
REQ-009 sched_sel  out  SEL_W*EGRESS_CNT  field i is the egress assigned to ingress i; drives the crossbar select directly.
REQ-010 sched_en  out  EGRESS_CNT  bit i set means ingress i is matched and its cell is forwarded.
REQ-011 match_cnt  out  16  count of matches (see Configuration).

Function
REQ-012 FSM states: IDLE, GRANT, ACCEPT, DONE. Transitions: IDLE->GRANT on start; GRANT->ACCEPT; ACCEPT->GRANT while iterations remain, otherwise ACCEPT->DONE; DONE->IDLE.
REQ-013 In IDLE, when start is high, voq_req shall be snapshotted; later voq_req changes shall not affect the schedule in progress.
REQ-014 Latency: start sampled at edge T; done shall be high during cycle T+1+2*ITER_CNT (T+5 at default).
REQ-015 start while busy shall be ignored and shall not be queued.
REQ-016 GRANT: each unmatched egress e grants one unmatched requesting ingress, searching round-robin from grant_ptr[e] upward with wrap; if there is no candidate, it grants none.
REQ-017 ACCEPT: each unmatched ingress i with at least one grant accepts one egress, searching round-robin from accept_ptr[i] with wrap; the accepted pair is recorded as matched.
REQ-018 Pointer update (iSLIP rule), first iteration only, for each accepted pair (i,e): grant_ptr[e] = (i+1) mod EGRESS_CNT and accept_ptr[i] = (e+1) mod EGRESS_CNT. Unaccepted grants shall not move pointers.
REQ-019 In DONE, sched_sel and sched_en shall be registered together; sched_en bit i = 1 exactly for matched ingresses.
REQ-020 sched_sel shall always be a permutation. Unmatched ingresses, in ascending index order, receive the unused egresses in ascending order. This keeps crossbar writes collision-free.
REQ-021 sched_sel and sched_en shall hold between done pulses and shall not change while busy.
REQ-022 An empty request matrix shall still complete with done, all sched_en bits 0, and the identity permutation.

Reset
REQ-023 Reset shall set: state IDLE; busy 0; done 0; sched_en 0; sched_sel field i = i; all grant_ptr and accept_ptr 0; match_cnt 0.
REQ-024 Reset mid-schedule shall abort: no done pulse, no pointer update, outputs take their reset values.

Configuration
REQ-025 Macro SCHED_STATS_EN defined: match_cnt adds popcount(sched_en) on each done, saturating at 16'hFFFF.
REQ-026 Macro SCHED_STATS_EN undefined: match_cnt is tied to 0 and no counter logic is synthesized. Scheduling behaviour is identical in both builds.

Verification (EGRESS_CNT=4, ITER_CNT=2)
REQ-027 After reset, start with voq_req=0 -> done at T+5, sched_en=4'b0000, sched_sel fields {3,2,1,0} (ingress 3 down to 0).
REQ-028 From reset, ingress i requests only egress (i+1)%4 -> sched_en=4'b1111, fields i=0..3 = {1,2,3,0}.
REQ-029 From reset, all ingresses request only egress 2 -> sched_en=4'b0001; fields i=0..3 = {2,0,1,3}. Repeat start -> ingress 1 is matched: sched_en=4'b0010, fields i=0..3 = {0,2,1,3}.
REQ-030 From reset, all 16 request bits set -> sched_en=4'b0011, fields i=0..3 = {0,1,2,3}. After this, grant_ptr[0]=1 and accept_ptr[0]=1; all other pointers remain 0.
REQ-031 start pulsed at T+2 is ignored, reset asserted at T+3 -> busy=0 at T+4, no done, a following REQ-027 run behaves as from reset.
REQ-032 With SCHED_STATS_EN, REQ-028 then REQ-029 (first run) -> match_cnt=5; without the macro -> match_cnt=0.
